// File: rtl/axi_slave_mem.sv
// AXI3-style memory slave with independent write (AW/W/B) and read (AR/R) FSMs over a word array.
// Optional AXI_SLAVE_WSTRB_EN enables per-byte write strobes; without it every accepted beat writes the full word.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam int IW = ADDR_WIDTH - SZ;
  localparam int MW = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [3:0] len);
    logic wrap_bad;
    wrap_bad = (burst == BURST_WRAP) &&
               !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    return (size != 3'(SZ)) || (burst == BURST_RSVD) || wrap_bad;
  endfunction

  // WRAP keeps the bits above len from the start index and wraps the low bits.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] burst,
                                             input logic [3:0] len);
    logic [IW-1:0] mask;
    mask = IW'(len);
    case (burst)
      BURST_FIXED: return idx;
      BURST_WRAP:  return (idx & ~mask) | ((idx + IW'(1)) & mask);
      default:     return idx + IW'(1);
    endcase
  endfunction

  function automatic logic out_of_range(input logic [IW-1:0] idx);
    return idx >= IW'(MEM_DEPTH);
  endfunction

  // ---------------- write channel ----------------
  wstate_t         wstate;
  logic [IW-1:0]   w_idx;
  logic [3:0]      w_len;
  logic [3:0]      w_cnt;
  logic [1:0]      w_burst;
  logic            w_cfg_err;
  logic            w_err_acc;
  logic [ID_WIDTH-1:0] w_id;
  logic            w_fire;
  logic            w_beat_err;
  logic            w_mem_we;

  assign w_fire     = wvalid && wready;
  assign w_beat_err = w_cfg_err || out_of_range(w_idx);
  assign w_mem_we   = w_fire && !w_beat_err && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      bid       <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= '0;
      w_cfg_err <= 1'b0;
      w_err_acc <= 1'b0;
      w_id      <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid && awready) begin
          w_id      <= awid;
          w_idx     <= awaddr[ADDR_WIDTH-1:SZ];
          w_len     <= awlen;
          w_burst   <= awburst;
          w_cfg_err <= cfg_err(awsize, awburst, awlen);
          w_err_acc <= 1'b0;
          w_cnt     <= '0;
          awready   <= 1'b0;
          wready    <= 1'b1;
          wstate    <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_idx     <= next_idx(w_idx, w_burst, w_len);
          w_cnt     <= w_cnt + 4'd1;
          w_err_acc <= w_err_acc || w_beat_err;
          // an early wlast still closes the burst
          if (wlast || w_cnt == w_len) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bid    <= w_id;
            bresp  <= (w_err_acc || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            wstate <= W_RESP;
          end
        end
        W_RESP: if (bvalid && bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wstate  <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
`ifdef AXI_SLAVE_WSTRB_EN
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (wstrb[b]) mem[w_idx[MW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
`else
      mem[w_idx[MW-1:0]] <= wdata;
`endif
    end
  end

  // ---------------- read channel ----------------
  rstate_t         rstate;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_len;
  logic [3:0]      r_cnt;
  logic [1:0]      r_burst;
  logic            r_cfg_err;
  logic [IW-1:0]   r_load_idx;
  logic            r_cfg_now;
  logic            r_load_err;
  logic [DATA_WIDTH-1:0] r_load_data;

  // The word presented next: the AR start in idle, else the successor of the current beat.
  always_comb begin
    r_load_idx = araddr[ADDR_WIDTH-1:SZ];
    r_cfg_now  = cfg_err(arsize, arburst, arlen);
    if (rstate == R_DATA) begin
      r_load_idx = next_idx(r_idx, r_burst, r_len);
      r_cfg_now  = r_cfg_err;
    end
    r_load_err  = r_cfg_now || out_of_range(r_load_idx);
    r_load_data = r_load_err ? '0 : mem[r_load_idx[MW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rresp     <= RESP_OKAY;
      rid       <= '0;
      rdata     <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid && arready) begin
          r_idx     <= r_load_idx;
          r_len     <= arlen;
          r_burst   <= arburst;
          r_cfg_err <= r_cfg_now;
          r_cnt     <= '0;
          rid       <= arid;
          rdata     <= r_load_data;
          rresp     <= r_load_err ? RESP_SLVERR : RESP_OKAY;
          rlast     <= (arlen == 4'd0);
          rvalid    <= 1'b1;
          arready   <= 1'b0;
          rstate    <= R_DATA;
        end
        R_DATA: if (rvalid && rready) begin
          if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end else begin
            r_idx <= r_load_idx;
            r_cnt <= r_cnt + 4'd1;
            rdata <= r_load_data;
            rresp <= r_load_err ? RESP_SLVERR : RESP_OKAY;
            rlast <= ((r_cnt + 4'd1) == r_len);
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{awaddr[SZ-1:0], araddr[SZ-1:0], wid, wstrb};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: master tasks, a burst-level memory model and a per-cycle R/B checker.
module tb_axi_slave_mem;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid = '0, wid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bbeat_t;
  rbeat_t exp_r[$];
  bbeat_t exp_b[$];
  logic [31:0] mdl [int];
  logic [31:0] wbuf [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  last_bresp;
  logic [3:0]  last_bid;

  function automatic int beat_word(input int start, input int burst, input int len, input int i);
    int n, base;
    if (burst == 0) return start;
    if (burst == 2) begin
      n = len + 1;
      base = (start / n) * n;
      return base + (start - base + i) % n;
    end
    return start + i;
  endfunction

  function automatic bit bad_cfg(input int size, input int burst, input int len);
    return size != 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  task automatic wait_hi(input int sel, input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      case (sel)
        0: seen = awready;
        1: seen = wready;
        2: seen = arready;
        default: seen = bvalid;
      endcase
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout waiting for %s", name);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb);
    bit err = 0;
    for (int i = 0; i <= len; i++) begin
      int w;
      logic [31:0] nv;
      w = beat_word(int'(addr >> 2), burst, len, i);
      if (bad_cfg(size, burst, len) || w >= DEPTH) err = 1;
      else begin
        nv = mdl.exists(w) ? mdl[w] : 32'h0;
`ifdef AXI_SLAVE_WSTRB_EN
        for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = wbuf[i][8*b +: 8];
`else
        nv = wbuf[i];
`endif
        mdl[w] = nv;
      end
    end
    exp_b.push_back('{id, err ? 2'b10 : 2'b00});
    awid = id; awaddr = addr; awlen = len[3:0]; awsize = size; awburst = burst; awvalid = 1'b1;
    wait_hi(0, "awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wid = id; wdata = wbuf[i]; wstrb = strb; wlast = (i == len); wvalid = 1'b1;
      wait_hi(1, "wready");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    wait_hi(3, "bvalid");
    last_bresp = bresp; last_bid = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size);
    for (int i = 0; i <= len; i++) begin
      int w;
      bit err;
      w = beat_word(int'(addr >> 2), burst, len, i);
      err = bad_cfg(size, burst, len) || w >= DEPTH;
      exp_r.push_back('{id, err ? 32'h0 : (mdl.exists(w) ? mdl[w] : 32'hx),
                        err ? 2'b10 : 2'b00, i == len});
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
    arid = id; araddr = addr; arlen = len[3:0]; arsize = size; arburst = burst; arvalid = 1'b1;
    wait_hi(2, "arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input logic [3:0] rpat);
    int nb = 0, c = 0;
    bit done = 0;
    model_read(id, addr, len, burst, size);
    send_ar(id, addr, len, burst, size);
    while (!done && c < 200) begin
      rready = rpat[c % 4];
      @(negedge clk);
      if (rvalid && rready) begin
        if (nb < 16) begin rd_data[nb] = rdata; rd_resp[nb] = rresp; rd_last[nb] = rlast; end
        nb++;
        if (rlast) done = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    rready = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout read burst at 0x%0h", addr);
    end
  endtask

  // ---------------- per-cycle checker ----------------
  initial begin : compare
    rbeat_t er;
    bbeat_t eb;
    logic held_v = 1'b0;
    logic [31:0] h_data;
    logic h_last;
    logic [1:0] h_resp;
    logic [3:0] h_id;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (held_v && rvalid) begin
          chk("r_stall_data", rdata, h_data);
          chk("r_stall_last", 32'(rlast), 32'(h_last));
          chk("r_stall_resp", 32'(rresp), 32'(h_resp));
          chk("r_stall_id", 32'(rid), 32'(h_id));
        end
        held_v = rvalid && !rready;
        h_data = rdata; h_last = rlast; h_resp = rresp; h_id = rid;
        if (rvalid && rready) begin
          if (exp_r.size() == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL r_unexpected: got beat 0x%0h expected none", rdata);
          end else begin
            er = exp_r.pop_front();
            chk("r_data", rdata, er.data);
            chk("r_id", 32'(rid), 32'(er.id));
            chk("r_resp", 32'(rresp), 32'(er.resp));
            chk("r_last", 32'(rlast), 32'(er.last));
          end
        end
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL b_unexpected: got bresp %0d expected none", bresp);
          end else begin
            eb = exp_b.pop_front();
            chk("b_id", 32'(bid), 32'(eb.id));
            chk("b_resp", 32'(bresp), 32'(eb.resp));
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_bresp_rresp", 32'({bresp, rresp}), 0);
    chk("rst_ids", 32'({bid, rid}), 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR write and readback
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    do_write(4'h5, 32'h100, 3, 2'b01, 3'd2, 4'hF);
    chk("incr_w_bresp", 32'(last_bresp), 0);
    chk("incr_w_bid", 32'(last_bid), 5);
    do_read(4'h3, 32'h100, 3, 2'b01, 3'd2, 4'b1111);
    chk("incr_r_d0", rd_data[0], 32'h11111111);
    chk("incr_r_d3", rd_data[3], 32'h44444444);
    chk("incr_r_last2", 32'(rd_last[2]), 0);
    chk("incr_r_last3", 32'(rd_last[3]), 1);

    // WRAP read starting mid-line
    do_read(4'h7, 32'h10C, 3, 2'b10, 3'd2, 4'b1111);
    chk("wrap_d0", rd_data[0], 32'h44444444);
    chk("wrap_d1", rd_data[1], 32'h11111111);
    chk("wrap_d3", rd_data[3], 32'h33333333);

    // FIXED write: last beat wins
    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002; wbuf[2] = 32'hCCCC0003;
    do_write(4'h1, 32'h200, 2, 2'b00, 3'd2, 4'hF);
    do_read(4'h1, 32'h200, 0, 2'b01, 3'd2, 4'b1111);
    chk("fixed_d0", rd_data[0], 32'hCCCC0003);
    chk("fixed_last", 32'(rd_last[0]), 1);

    // burst crossing the top of memory
    wbuf[0] = 32'h5A5A5A5A; wbuf[1] = 32'hDEADBEEF;
    do_write(4'h2, DEPTH * 4 - 4, 1, 2'b01, 3'd2, 4'hF);
    chk("edge_w_bresp", 32'(last_bresp), 2);
    do_read(4'h2, DEPTH * 4 - 4, 1, 2'b01, 3'd2, 4'b1111);
    chk("edge_r_resp0", 32'(rd_resp[0]), 0);
    chk("edge_r_d0", rd_data[0], 32'h5A5A5A5A);
    chk("edge_r_resp1", 32'(rd_resp[1]), 2);
    chk("edge_r_d1", rd_data[1], 0);

    // illegal size and reserved burst
    do_read(4'h9, 32'h100, 1, 2'b01, 3'd1, 4'b1111);
    chk("size_err_resp", 32'(rd_resp[0]), 2);
    chk("size_err_d", rd_data[1], 0);
    wbuf[0] = 32'h12345678; wbuf[1] = 32'h9ABCDEF0;
    do_write(4'h4, 32'h180, 1, 2'b11, 3'd2, 4'hF);
    chk("rsvd_w_bresp", 32'(last_bresp), 2);

    // stalled read
    do_read(4'hA, 32'h100, 3, 2'b01, 3'd2, 4'b1001);
    chk("stall_d1", rd_data[1], 32'h22222222);
    chk("stall_d2", rd_data[2], 32'h33333333);

    // reset during the second beat
    model_read(4'hB, 32'h100, 3, 2'b01, 3'd2);
    send_ar(4'hB, 32'h100, 3, 2'b01, 3'd2);
    rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid), 0);
    chk("midrst_arready", 32'(arready), 1);
    chk("midrst_exp_left", exp_r.size(), 3);
    exp_r.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // byte strobes
    wbuf[0] = 32'hFFFFFFFF;
    do_write(4'h6, 32'h300, 0, 2'b01, 3'd2, 4'hF);
    wbuf[0] = 32'h00000000;
    do_write(4'h6, 32'h300, 0, 2'b01, 3'd2, 4'b0101);
    do_read(4'h6, 32'h300, 0, 2'b01, 3'd2, 4'b1111);
`ifdef AXI_SLAVE_WSTRB_EN
    chk("strb_d", rd_data[0], 32'hFF00FF00);
`else
    chk("strb_d", rd_data[0], 32'h00000000);
`endif

    repeat (5) @(posedge clk);
    chk("exp_r_drained", exp_r.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Synthesizable AXI3-style memory slave: the responder end of the AXI_AW/W/B/AR/R channels driven by the bench master.
- Accepts write and read bursts (FIXED/INCR/WRAP) into an internal word-addressed array. Returns B and R responses.
- Used as the bridge test target and as a golden memory model in bench regressions.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; only full-width transfers are supported
ID_WIDTH, 4, AXI ID width
MEM_DEPTH, 1024, array depth in DATA_WIDTH words; valid byte range 0 .. MEM_DEPTH*DATA_WIDTH/8-1

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous reset, active low
awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/4/3/2  write address
awvalid  in  1 ; awready  out  1  write address handshake
wid/wdata/wstrb/wlast  in  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  write data
wvalid  in  1 ; wready  out  1  write data handshake
bid/bresp  out  ID_WIDTH/2 ; bvalid  out  1 ; bready  in  1  write response
arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/4/3/2  read address
arvalid  in  1 ; arready  out  1  read address handshake
rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1 ; rvalid  out  1 ; rready  in  1  read data

Behaviour:
- Reset (rst_n=0 at posedge): both FSMs go to IDLE. awready=1, arready=1. wready=0, bvalid=0, rvalid=0, rlast=0. bresp, rresp, bid, rid and rdata are 0. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- Write FSM has states W_IDLE, W_DATA and W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, latch id, addr, len, size and burst, then go to W_DATA (wready=1 next cycle, awready=0).
  - W_DATA: each wvalid&wready beat writes the current address and advances it. A beat with wlast=1, or beat count == len+1, goes to W_RESP. wlast is taken as the end of the burst even if it arrives early.
  - W_RESP: bvalid=1 and bid = latched awid. bvalid holds until bready. Return to W_IDLE the cycle after bvalid&bready.
- Read FSM has states R_IDLE and R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch the read fields and go to R_DATA.
  - The first rvalid appears the cycle after the AR handshake (1-cycle latency).
  - R_DATA: rdata, rid, rresp and rlast are held stable while rvalid&!rready. Each rvalid&rready advances the address and loads the next word in the same edge, so back-to-back beats run at full rate. rlast=1 on beat len. After the last handshake, go to R_IDLE with rvalid=0.
- Address generation works on the word index (addr >> log2(DATA_WIDTH/8)):
  - FIXED: the address is constant.
  - INCR: the index increments by 1.
  - WRAP: the wrap size is len+1 words (legal len 1, 3, 7, 15). Wrap boundary = start index aligned down to len+1; the index wraps to the boundary after reaching boundary+len.
  - Reserved burst 2'b11 is treated as INCR with SLVERR.
- Errors (resp=2'b10 SLVERR) are raised for:
  - any beat address >= MEM_DEPTH words;
  - size != log2(DATA_WIDTH/8);
  - burst == 2'b11;
  - WRAP with an illegal len.
  - Erroneous write beats do not modify memory. bresp is SLVERR if any beat erred. Erroneous read beats return rdata=0 with rresp=SLVERR per beat. Beats are always consumed so the protocol completes.
- Read and write channels are fully independent and may be active in the same cycle. If both hit the same word on one edge, the read returns the pre-write data.
- wid is not checked against awid.

Optional Feature:
- Macro: AXI_SLAVE_WSTRB_EN.
- Defined: only the byte lanes with wstrb[i]=1 are written; the other bytes keep their old value.
- Undefined: wstrb is ignored and every accepted beat writes the full word.

Test Plan:
- INCR write, len=3 at 0x100, data 0x11111111..0x44444444 -> bresp=OKAY, bid=awid. INCR read of the same range -> the four words in order, rlast only on beat 3, rresp=OKAY.
- WRAP read, len=3 at 0x10C, after the previous write -> word order 0x44444444, 0x11111111, 0x22222222, 0x33333333.
- FIXED write, len=2 at 0x200 with data A, B, C -> read of 0x200 returns C.
- Write len=1 at byte address MEM_DEPTH*4-4 -> bresp=SLVERR. The in-range word is written, the out-of-range beat is dropped, and a read back shows rresp OKAY then SLVERR with rdata=0.
- Read with rready toggled 1-0-0-1 -> rdata/rlast stay stable while stalled and no beat is skipped or duplicated. Assert rst_n=0 during the second beat -> rvalid=0 and arready=1 the next cycle.
- With AXI_SLAVE_WSTRB_EN: write 0xFFFFFFFF, then 0x00000000 with wstrb=4'b0101 -> readback 0xFF00FF00. Without the macro -> readback 0x00000000.
